bist_pattern_ctrl: RTL

BIST_PATTERN_CTRL -- requirements
Module: bist_pattern_ctrl

---
 rtl/bist_pkg.sv | 23 ++
 rtl/bist_misr.sv | 38 +++
 rtl/bist_pattern_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST pattern controller
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int SIG_W_DEF = 16;

  localparam logic [3:0]  LFSR_SEED = 4'b0001;
  // Feedback taps on bits 3 and 2: maximal length (15) for a 4-bit register
  localparam logic [3:0]  LFSR_TAPS = 4'b1100;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  function automatic logic [3:0] lfsr_next(input logic [3:0] l);
    return {l[2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - serial-input multiple-input signature register
module bist_misr
  import bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             si_i,
  output logic [SIG_W-1:0] sig_o
);

  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr_i) begin
      sig_d = '0;
    end else if (en_i) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ si_i) ? POLY : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_pattern_ctrl.sv
// rtl/bist_pattern_ctrl.sv - BIST session controller: LFSR stimulus, pattern count, MISR compaction
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SIG_W = SIG_W_DEF
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] golden,
  output logic [3:0]       pi,
  output logic             cut_reset,
  input  logic             po,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  state_e           state_q, state_d;
  logic [3:0]       lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [CNT_W:0]   cnt_inc;

  // One extra bit so the terminal compare cannot alias on wrap
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    golden_d = golden_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_INIT;
          count_d  = num_patterns;
          golden_d = golden;
        end
      end
      ST_INIT: begin
        lfsr_d  = LFSR_SEED;
        cnt_d   = '0;
        state_d = (count_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        lfsr_d = lfsr_next(lfsr_q);
        cnt_d  = cnt_inc[CNT_W-1:0];
        if (cnt_inc == {1'b0, count_q}) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      cnt_q    <= '0;
      count_q  <= '0;
      golden_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      golden_q <= golden_d;
    end
  end

  bist_misr #(
    .SIG_W(SIG_W)
  ) u_misr (
    .clk_i(CK),
    .rst_i(reset),
    .clr_i(state_q == ST_INIT),
    .en_i (state_q == ST_RUN),
    .si_i (po),
    .sig_o(signature)
  );

  // Outputs decode directly from state so an asynchronous reset takes effect at once
  assign busy      = (state_q == ST_INIT) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pi        = (state_q == ST_RUN) ? lfsr_q : 4'b0000;
  assign cut_reset = reset || (state_q == ST_INIT);
  assign pass      = done && (signature == golden_q);

endmodule
